dcache_axi_master: RTL



---
 rtl/axi_pkg.sv | 31 +++
 rtl/dmem_strb_gen.sv | 33 +++
 rtl/dcache_axi_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, cache access-type codes and the bridge state type
// for the data-cache memory bridge.
package axi_pkg;

  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [AXI_SIZE_BITS-1:0] SIZE_BYTE = 3'd0;
  localparam logic [AXI_SIZE_BITS-1:0] SIZE_HALF = 3'd1;
  localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD = 3'd2;

  // Cache access-type encoding shared with the data cache
  localparam int CACHE_TYPE_BITS = 3;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE    = 3'd0;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE_U  = 3'd1;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HWORD   = 3'd2;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HWORD_U = 3'd3;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_WORD    = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

endpackage

// File: rtl/dmem_strb_gen.sv
// Store byte-lane strobe and AXI transfer size from cache access type and
// the low address bits. Unknown access types produce an empty strobe.
module dmem_strb_gen
  import axi_pkg::*;
(
  input  logic [CACHE_TYPE_BITS-1:0] d_type,
  input  logic [1:0]                 addr_lo,
  output logic [3:0]                 strb,
  output logic [AXI_SIZE_BITS-1:0]   size
);

  // Decode lane mask and size for the requested access width
  always_comb begin
    strb = 4'b0000;
    size = SIZE_WORD;
    case (d_type)
      CACHE_BYTE, CACHE_BYTE_U: begin
        strb = 4'b0001 << addr_lo;
        size = SIZE_BYTE;
      end
      CACHE_HWORD, CACHE_HWORD_U: begin
        strb = 4'b0011 << {addr_lo[1], 1'b0};
        size = SIZE_HALF;
      end
      CACHE_WORD: begin
        strb = 4'b1111;
        size = SIZE_WORD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_axi_master.sv
// Data-cache to AXI4 master bridge: line refills become reads, write-through
// stores become single-beat strobed writes.
// Build option DCACHE_READ_BURST_EN: refill as one 4-beat INCR burst; when
// undefined, refill as four sequential single-beat reads.
module dcache_axi_master
  import axi_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter int unsigned MASTER_ID = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       D_req,
  input  logic [31:0]                D_addr,
  input  logic                       D_write,
  input  logic [31:0]                D_in,
  input  logic [CACHE_TYPE_BITS-1:0] D_type,
  output logic [31:0]                D_out,
  output logic                       D_wait,
  output logic [ID_W-1:0]            ARID,
  output logic [31:0]                ARADDR,
  output logic [AXI_LEN_BITS-1:0]    ARLEN,
  output logic [AXI_SIZE_BITS-1:0]   ARSIZE,
  output logic [1:0]                 ARBURST,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [ID_W-1:0]            RID,
  input  logic [31:0]                RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RLAST,
  input  logic                       RVALID,
  output logic                       RREADY,
  output logic [ID_W-1:0]            AWID,
  output logic [31:0]                AWADDR,
  output logic [AXI_LEN_BITS-1:0]    AWLEN,
  output logic [AXI_SIZE_BITS-1:0]   AWSIZE,
  output logic [1:0]                 AWBURST,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [31:0]                WDATA,
  output logic [3:0]                 WSTRB,
  output logic                       WLAST,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic [ID_W-1:0]            BID,
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY
);

`ifdef DCACHE_READ_BURST_EN
  localparam logic [AXI_LEN_BITS-1:0] RD_LEN = 4'd3;
`else
  localparam logic [AXI_LEN_BITS-1:0] RD_LEN = 4'd0;
`endif

  state_t                     state;
  logic [1:0]                 beat;
  logic                       aw_done;
  logic                       w_done;
  logic                       aw_fin;
  logic                       w_fin;
  logic [3:0]                 strb_gen;
  logic [AXI_SIZE_BITS-1:0]   size_gen;
  logic                       unused_inputs;

  // Response status and IDs never alter the transaction outcome
  assign unused_inputs = ^{RID, RRESP, RLAST, BID, BRESP};

  dmem_strb_gen u_strb (
    .d_type  (D_type),
    .addr_lo (D_addr[1:0]),
    .strb    (strb_gen),
    .size    (size_gen)
  );

  assign aw_fin = aw_done | (AWVALID & AWREADY);
  assign w_fin  = w_done  | (WVALID  & WREADY);

  // Fixed AXI attributes are qualified by their VALID so idle buses read 0
  assign ARID    = ARVALID ? ID_W'(MASTER_ID) : '0;
  assign ARLEN   = ARVALID ? RD_LEN : '0;
  assign ARSIZE  = ARVALID ? SIZE_WORD : '0;
  assign ARBURST = ARVALID ? BURST_INCR : '0;
  assign AWID    = AWVALID ? ID_W'(MASTER_ID) : '0;
  assign AWLEN   = '0;
  assign AWBURST = AWVALID ? BURST_INCR : '0;
  assign WLAST   = WVALID;
  assign D_out   = (state == RD_DATA) ? RDATA : '0;

  // Cache stall: released for one cycle per accepted beat or write response
  always_comb begin
    D_wait = 1'b0;
    case (state)
      IDLE:    D_wait = D_req & ~rst;
      RD_ADDR: D_wait = 1'b1;
      RD_DATA: D_wait = ~RVALID;
      WR_REQ:  D_wait = 1'b1;
      WR_RESP: D_wait = ~BVALID;
      default: D_wait = 1'b0;
    endcase
  end

  // Transaction sequencer with registered channel controls and payloads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ARVALID <= 1'b0;
      ARADDR  <= '0;
      RREADY  <= 1'b0;
      AWVALID <= 1'b0;
      AWADDR  <= '0;
      AWSIZE  <= '0;
      WVALID  <= 1'b0;
      WDATA   <= '0;
      WSTRB   <= '0;
      BREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (D_req) begin
            beat <= 2'd0;
            if (D_write) begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              AWADDR  <= D_addr;
              AWSIZE  <= size_gen;
              WDATA   <= D_in;
              WSTRB   <= strb_gen;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end else begin
              ARVALID <= 1'b1;
              ARADDR  <= {D_addr[31:4], 4'b0000};
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Beat count, not RLAST, ends the refill
          if (RVALID) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              RREADY <= 1'b0;
              state  <= IDLE;
            end
`ifndef DCACHE_READ_BURST_EN
            else begin
              RREADY  <= 1'b0;
              ARVALID <= 1'b1;
              ARADDR  <= {ARADDR[31:4], beat + 2'd1, 2'b00};
              state   <= RD_ADDR;
            end
`endif
          end
        end
        WR_REQ: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
